// File: rtl/nmx_wb_bank_fabric_if.sv
// nmx_wb_bank_fabric_if: user-project Wishbone classic port bundle.
// The master drives the request; the slave returns ack and read data.
interface nmx_wb_bank_fabric_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i,
        output wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
        input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/nmx_wb_bank_fabric.sv
// nmx_wb_bank_fabric: Wishbone fan-out to NUM_BANKS Neuromorphic_X1 banks
// with a hung-bank watchdog and a CSR window in region 15.
// Optional: define NMX_PERF_CNT_EN for per-bank completed-ack counters.
module nmx_wb_bank_fabric #(
    parameter int          NUM_BANKS   = 4,
    parameter int          BANK_ADDR_W = 16,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_0000
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    nmx_wb_bank_fabric_if.slave      wbs,
    output logic [NUM_BANKS-1:0]     bk_stb_o,
    output logic                     bk_we_o,
    output logic [3:0]               bk_sel_o,
    output logic [BANK_ADDR_W-1:0]   bk_adr_o,
    output logic [31:0]              bk_dat_o,
    input  logic [32*NUM_BANKS-1:0]  bk_dat_i,
    input  logic [NUM_BANKS-1:0]     bk_ack_i,
    output logic                     irq_o
);
    localparam logic [3:0]  CSR_REGION = 4'hF;
    localparam logic [15:0] WD_LAST    = 16'(TIMEOUT_CYC - 1);
`ifdef NMX_PERF_CNT_EN
    localparam logic [31:0] ID_WORD = {8'h4E, 8'(NUM_BANKS), 16'h8001};
`else
    localparam logic [31:0] ID_WORD = {8'h4E, 8'(NUM_BANKS), 16'h0001};
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_BANK,
        S_LOCAL,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [3:0]           reg_r;
    logic [15:0]          wd_cnt;
    logic                 ack_q;
    logic [31:0]          dat_q;
    logic                 irq_q;
    logic [NUM_BANKS-1:0] toflag_q;
    logic [NUM_BANKS-1:0] enable_q;
    logic                 irq_en_q;

    logic [3:0]           req_r;
    logic                 req_go;
    logic                 req_bank;
    logic [NUM_BANKS-1:0] req_oh;
    logic                 sel_ack;
    logic [31:0]          sel_dat;
    logic                 wd_exp;
    logic                 bank_done;
    logic                 bank_to;
    logic [7:0]           csr_off;
    logic                 csr_hit;
    logic                 csr_wr_full;
    logic [31:0]          csr_rd;
    logic [31:0]          local_rd;
    logic [NUM_BANKS-1:0] to_set;
    logic [NUM_BANKS-1:0] to_clr;
    logic                 unused_ok;

`ifdef NMX_PERF_CNT_EN
    logic [31:0] perf_q [NUM_BANKS];
`endif

    assign req_r       = wbs.wbs_adr_i[BANK_ADDR_W+3:BANK_ADDR_W];
    assign req_go      = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
    assign wd_exp      = (wd_cnt == WD_LAST);
    assign csr_off     = bk_adr_o[7:0];
    assign csr_hit     = (state_q == S_LOCAL) && (reg_r == CSR_REGION);
    assign csr_wr_full = csr_hit && bk_we_o && (bk_sel_o == 4'hF);
    assign local_rd    = (reg_r == CSR_REGION && !bk_we_o) ? csr_rd : '0;
    assign to_clr      = (csr_wr_full && csr_off == 8'h00) ?
                         bk_dat_o[NUM_BANKS-1:0] : '0;
    assign unused_ok   = ^wbs.wbs_adr_i[31:BANK_ADDR_W+4];

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign irq_o         = irq_q;

    // Per-bank lookups for the incoming region and the held region.
    always_comb begin
        req_bank = 1'b0;
        req_oh   = '0;
        sel_ack  = 1'b0;
        sel_dat  = '0;
        to_set   = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            req_oh[i] = (req_r == 4'(i));
            if (req_r == 4'(i) && enable_q[i]) req_bank = 1'b1;
            if (reg_r == 4'(i)) begin
                sel_ack   = bk_ack_i[i];
                sel_dat   = bk_dat_i[32*i +: 32];
                to_set[i] = bank_to;
            end
        end
    end

    // Next state: one transaction in flight, bank or local response.
    always_comb begin
        state_d   = state_q;
        bank_done = 1'b0;
        bank_to   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_go) state_d = req_bank ? S_BANK : S_LOCAL;
            end
            S_BANK: begin
                if (!wbs.wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (sel_ack) begin
                    bank_done = 1'b1;
                    state_d   = S_RESP;
                end else if (wd_exp) begin
                    bank_to = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_LOCAL: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // CSR read mux over the latched offset.
    always_comb begin
        csr_rd = '0;
        case (csr_off)
            8'h00: csr_rd[NUM_BANKS-1:0] = toflag_q;
            8'h04: csr_rd[NUM_BANKS-1:0] = enable_q;
            8'h08: csr_rd[0] = irq_en_q;
            8'h0C: csr_rd = ID_WORD;
            default: begin
`ifdef NMX_PERF_CNT_EN
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (csr_off == 8'(16 + 4*i)) csr_rd = perf_q[i];
                end
`endif
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Latch the request, drive the bank strobe and run the watchdog.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bk_stb_o <= '0;
            bk_we_o  <= 1'b0;
            bk_sel_o <= '0;
            bk_adr_o <= '0;
            bk_dat_o <= '0;
            reg_r    <= '0;
            wd_cnt   <= '0;
        end else begin
            if (state_q == S_IDLE && req_go) begin
                bk_we_o  <= wbs.wbs_we_i;
                bk_sel_o <= wbs.wbs_sel_i;
                bk_adr_o <= wbs.wbs_adr_i[BANK_ADDR_W-1:0];
                bk_dat_o <= wbs.wbs_dat_i;
                reg_r    <= req_r;
                wd_cnt   <= '0;
                if (req_bank) bk_stb_o <= req_oh;
            end
            if (state_q == S_BANK) begin
                wd_cnt <= wd_cnt + 16'd1;
                if (state_d != S_BANK) bk_stb_o <= '0;
            end
        end
    end

    // Registered ack, read data and interrupt.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ack_q <= (state_d == S_RESP);
            irq_q <= irq_en_q & (|toflag_q);
            if (bank_done)              dat_q <= sel_dat;
            else if (bank_to)           dat_q <= ERR_DATA | {28'd0, reg_r};
            else if (state_q == S_LOCAL) dat_q <= local_rd;
        end
    end

    // Control registers; a timeout set beats a same-cycle clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            toflag_q <= '0;
            enable_q <= '1;
            irq_en_q <= 1'b0;
        end else begin
            toflag_q <= (toflag_q & ~to_clr) | to_set;
            if (csr_wr_full && csr_off == 8'h04)
                enable_q <= bk_dat_o[NUM_BANKS-1:0];
            if (csr_wr_full && csr_off == 8'h08)
                irq_en_q <= bk_dat_o[0];
        end
    end

`ifdef NMX_PERF_CNT_EN
    // Count completed bank acks; any write to a counter clears it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_BANKS; i++) perf_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (csr_hit && bk_we_o && csr_off == 8'(16 + 4*i))
                    perf_q[i] <= '0;
                else if (bank_done && reg_r == 4'(i))
                    perf_q[i] <= perf_q[i] + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_nmx_wb_bank_fabric.sv
// tb_nmx_wb_bank_fabric: random Wishbone traffic against a transaction-level
// model of the bank fabric, plus directed reset, timeout and abort cases.
module tb_nmx_wb_bank_fabric;
    localparam int NB    = 4;
    localparam int TO    = 8;
    localparam int NEVER = 1000;
`ifdef NMX_PERF_CNT_EN
    localparam logic [31:0] ID_EXP = 32'h4E04_8001;
`else
    localparam logic [31:0] ID_EXP = 32'h4E04_0001;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NB-1:0]    bk_stb;
    logic             bk_we;
    logic [3:0]       bk_sel;
    logic [15:0]      bk_adr;
    logic [31:0]      bk_wdat;
    logic [32*NB-1:0] bk_dat = '0;
    logic [NB-1:0]    bk_ack = '0;
    logic             irq;

    nmx_wb_bank_fabric_if w ();

    nmx_wb_bank_fabric #(
        .NUM_BANKS(NB), .BANK_ADDR_W(16),
        .TIMEOUT_CYC(TO), .ERR_DATA(32'hDEAD_0000)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(w),
        .bk_stb_o(bk_stb), .bk_we_o(bk_we), .bk_sel_o(bk_sel),
        .bk_adr_o(bk_adr), .bk_dat_o(bk_wdat), .bk_dat_i(bk_dat),
        .bk_ack_i(bk_ack), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bank environment: ack after bank_delay strobed cycles, random noise acks.
    int          bank_delay [NB];
    int          scnt [NB];
    logic [31:0] bank_mem [NB][64];
    bit          noise = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (bk_stb[i]) begin
                scnt[i] = scnt[i] + 1;
                if (scnt[i] == bank_delay[i]) begin
                    if (bk_we)
                        for (int b = 0; b < 4; b++)
                            if (bk_sel[b])
                                bank_mem[i][bk_adr[7:2]][8*b +: 8] = bk_wdat[8*b +: 8];
                    bk_dat[32*i +: 32] = bank_mem[i][bk_adr[7:2]];
                    bk_ack[i] = 1'b1;
                end else begin
                    bk_ack[i] = 1'b0;
                    bk_dat[32*i +: 32] = $urandom;
                end
            end else begin
                scnt[i] = 0;
                bk_ack[i] = noise && ($urandom_range(0, 3) == 0);
                bk_dat[32*i +: 32] = $urandom;
            end
        end
    end

    // Reference model state.
    logic [NB-1:0] m_en;
    logic [NB-1:0] m_to;
    logic          m_irqen;
    logic [31:0]   m_perf [NB];
    logic [31:0]   ref_mem [NB][64];

    task automatic model_reset();
        m_en = '1;
        m_to = '0;
        m_irqen = 1'b0;
        for (int i = 0; i < NB; i++) m_perf[i] = '0;
    endtask

    task automatic model(input bit we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input int d, output logic [31:0] erd,
                         output int elat, output logic [NB-1:0] estb);
        int r;
        int o;
        int idx;
        r = int'(adr[19:16]);
        o = int'(adr[7:0]);
        idx = int'(adr[7:2]);
        erd = '0;
        estb = '0;
        elat = 2;
        if (r < NB && m_en[r]) begin
            estb[r] = 1'b1;
            if (d <= TO) begin
                elat = d + 1;
                m_perf[r] = m_perf[r] + 1;
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) ref_mem[r][idx][8*b +: 8] = dat[8*b +: 8];
                end else begin
                    erd = ref_mem[r][idx];
                end
            end else begin
                elat = TO + 1;
                erd = 32'hDEAD_0000 + r;
                m_to[r] = 1'b1;
            end
        end else if (r == 15) begin
            if (!we) begin
                if (o == 0) erd[NB-1:0] = m_to;
                else if (o == 4) erd[NB-1:0] = m_en;
                else if (o == 8) erd[0] = m_irqen;
                else if (o == 12) erd = ID_EXP;
`ifdef NMX_PERF_CNT_EN
                else if (o >= 16 && o < 16 + 4*NB && o % 4 == 0)
                    erd = m_perf[(o - 16) / 4];
`endif
            end else begin
                if (sel == 4'hF) begin
                    if (o == 0) m_to = m_to & ~dat[NB-1:0];
                    else if (o == 4) m_en = dat[NB-1:0];
                    else if (o == 8) m_irqen = dat[0];
                end
`ifdef NMX_PERF_CNT_EN
                if (o >= 16 && o < 16 + 4*NB && o % 4 == 0)
                    m_perf[(o - 16) / 4] = '0;
`endif
            end
        end
    endtask

    task automatic xfer(input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output logic [31:0] rd, output int lat,
                        output logic [NB-1:0] stb1, output logic [15:0] adr1,
                        output logic [31:0] dat1);
        lat = -1;
        rd = '0;
        stb1 = '0;
        adr1 = '0;
        dat1 = '0;
        @(negedge clk);
        w.wbs_cyc_i = 1'b1;
        w.wbs_stb_i = 1'b1;
        w.wbs_we_i  = we;
        w.wbs_sel_i = sel;
        w.wbs_adr_i = adr;
        w.wbs_dat_i = dat;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                stb1 = bk_stb;
                adr1 = bk_adr;
                dat1 = bk_wdat;
            end
            if (w.wbs_ack_o) begin
                lat = k;
                rd = w.wbs_dat_o;
                break;
            end
        end
        w.wbs_cyc_i = 1'b0;
        w.wbs_stb_i = 1'b0;
        w.wbs_we_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input bit we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input int d, output logic [31:0] rd);
        logic [31:0]   erd;
        int            elat;
        int            lat;
        logic [NB-1:0] estb;
        logic [NB-1:0] stb1;
        logic [15:0]   adr1;
        logic [31:0]   dat1;
        int            r;
        r = int'(adr[19:16]);
        if (r < NB) bank_delay[r] = d;
        model(we, adr, dat, sel, d, erd, elat, estb);
        xfer(we, adr, dat, sel, rd, lat, stb1, adr1, dat1);
        chk("ack_latency", lat, elat);
        chk("bank_stb", stb1, estb);
        if (estb != '0) begin
            chk("bank_adr", adr1, adr[15:0]);
            chk("bank_wdat", dat1, dat);
        end
        if (!we) chk("read_data", rd, erd);
        chk("irq", irq, m_irqen & (|m_to));
    endtask

    function automatic logic [31:0] csr_adr(input logic [7:0] off);
        return {12'h0, 4'hF, 8'h00, off};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    logic [31:0] rd, adr, dat;
    logic [3:0]  sel, r;
    int          kind, d, off;
    bit          we, seen;
    int          offs [10] = '{0, 4, 8, 12, 16, 20, 24, 28, 32, 3};

    initial begin
        w.wbs_cyc_i = 1'b0;
        w.wbs_stb_i = 1'b0;
        w.wbs_we_i  = 1'b0;
        w.wbs_sel_i = '0;
        w.wbs_adr_i = '0;
        w.wbs_dat_i = '0;
        for (int i = 0; i < NB; i++) begin
            bank_delay[i] = NEVER;
            scnt[i] = 0;
            for (int j = 0; j < 64; j++) begin
                bank_mem[i][j] = $urandom;
                ref_mem[i][j] = bank_mem[i][j];
            end
        end
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_ack", w.wbs_ack_o, 0);
        chk("rst_dat", w.wbs_dat_o, 0);
        chk("rst_stb", bk_stb, 0);
        chk("rst_bank_bus", {bk_we, bk_sel, bk_adr, bk_wdat}, 0);
        chk("rst_irq", irq, 0);
        rst = 1'b0;
        noise = 1'b1;
        @(negedge clk);

        run(0, csr_adr(8'h0C), 0, 4'hF, 1, rd);
        chk("id_word", rd, ID_EXP);
        run(0, csr_adr(8'h04), 0, 4'hF, 1, rd);
        chk("enable_reset", rd, 32'hF);

        run(1, 32'h0002_0040, 32'h1234_5678, 4'hF, 3, rd);
        run(0, 32'h0002_0040, 0, 4'hF, 2, rd);
        chk("bank2_readback", rd, 32'h1234_5678);

        run(1, csr_adr(8'h08), 1, 4'hF, 1, rd);
        run(0, 32'h0001_0010, 0, 4'hF, NEVER, rd);
        chk("timeout_data", rd, 32'hDEAD_0001);
        chk("timeout_irq", irq, 1);
        run(0, csr_adr(8'h00), 0, 4'hF, 1, rd);
        chk("toflag_set", rd, 32'h2);
        run(1, csr_adr(8'h00), 2, 4'hF, 1, rd);
        run(0, csr_adr(8'h00), 0, 4'hF, 1, rd);
        chk("toflag_clear", rd, 0);
        chk("irq_clear", irq, 0);

        run(0, 32'h0000_0020, 0, 4'hF, TO, rd);
        run(0, 32'h0000_0020, 0, 4'hF, TO + 1, rd);

        run(1, csr_adr(8'h04), 32'hB, 4'hF, 1, rd);
        run(0, 32'h0002_0040, 0, 4'hF, 1, rd);
        run(1, csr_adr(8'h04), 32'hF, 4'hF, 1, rd);
        run(0, 32'h0007_0000, 0, 4'hF, 1, rd);

        bank_delay[1] = NEVER;
        @(negedge clk);
        w.wbs_cyc_i = 1'b1;
        w.wbs_stb_i = 1'b1;
        w.wbs_we_i  = 1'b0;
        w.wbs_adr_i = 32'h0001_0000;
        @(negedge clk);
        chk("abort_stb_on", bk_stb, 4'b0010);
        repeat (2) @(negedge clk);
        w.wbs_cyc_i = 1'b0;
        w.wbs_stb_i = 1'b0;
        @(negedge clk);
        chk("abort_stb_off", bk_stb, 0);
        seen = 1'b0;
        repeat (12) begin
            if (w.wbs_ack_o) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_ack", seen, 0);
        run(0, csr_adr(8'h00), 0, 4'hF, 1, rd);

        bank_delay[3] = NEVER;
        @(negedge clk);
        w.wbs_cyc_i = 1'b1;
        w.wbs_stb_i = 1'b1;
        w.wbs_adr_i = 32'h0003_0000;
        repeat (2) @(negedge clk);
        chk("midrst_stb_on", bk_stb, 4'b1000);
        rst = 1'b1;
        #1;
        chk("midrst_stb_off", bk_stb, 0);
        chk("midrst_ack", w.wbs_ack_o, 0);
        w.wbs_cyc_i = 1'b0;
        w.wbs_stb_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef NMX_PERF_CNT_EN
        run(1, csr_adr(8'h10), 0, 4'hF, 1, rd);
        repeat (5) run(0, 32'h0000_0004, 0, 4'hF, 2, rd);
        run(0, csr_adr(8'h10), 0, 4'hF, 1, rd);
        chk("perf_count", rd, 5);
        run(1, csr_adr(8'h10), 0, 4'h1, 1, rd);
        run(0, csr_adr(8'h10), 0, 4'hF, 1, rd);
        chk("perf_clear", rd, 0);
`endif

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            we = 1'($urandom_range(0, 1));
            dat = $urandom;
            sel = 4'hF;
            d = ($urandom_range(0, 4) == 0) ? NEVER : $urandom_range(1, 10);
            if (kind <= 5) begin
                r = 4'($urandom_range(0, NB - 1));
                if (we) sel = 4'($urandom_range(1, 15));
                adr = {12'($urandom), r, 16'($urandom)};
            end else if (kind <= 7) begin
                off = offs[$urandom_range(0, 9)];
                if ($urandom_range(0, 3) == 0) sel = 4'($urandom);
                if (off == 4 && dat[NB-1:0] == '0) dat[0] = 1'b1;
                adr = {12'($urandom), 4'hF, 8'($urandom), 8'(off)};
            end else begin
                r = 4'($urandom_range(NB, 14));
                adr = {12'($urandom), r, 16'($urandom)};
            end
            run(we, adr, dat, sel, d, rd);
        end

        for (int i = 0; i < 8; i++) run(0, csr_adr(8'(4*i)), 0, 4'hF, 1, rd);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/nmx_wb_bank_fabric.md
Name: nmx_wb_bank_fabric

Overview:
- Wishbone classic slave that fronts NUM_BANKS Neuromorphic_X1 macro instances behind one user-project Wishbone port.
- Successor to the single-macro wrapper hookup; sits between the Caravel Wishbone bus and the per-bank macro Wishbone ports.
- Decodes a 4-bit region index, forwards one registered transaction at a time to the selected bank, and aborts hung banks with a timeout watchdog.
- Exposes a CSR window for bank enables, sticky timeout flags and an interrupt.

Parameters:
- NUM_BANKS, 4, number of macro banks; legal range 1..15.
- BANK_ADDR_W, 16, byte-address width of each bank window.
- TIMEOUT_CYC, 255, cycles a bank may hold off its ack before abort; legal range 1..65535.
- ERR_DATA, 32'hDEAD_0000, read-data base returned on a timeout.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone master controls.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address; only bits [BANK_ADDR_W+3:0] are used.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle ack.
- wbs_dat_o  out  32  read data, registered.
- bk_stb_o  out  NUM_BANKS  one-hot bank strobe; also drives the bank cyc.
- bk_we_o  out  1  write enable to the banks.
- bk_sel_o  out  4  byte selects to the banks.
- bk_adr_o  out  BANK_ADDR_W  in-bank address.
- bk_dat_o  out  32  write data to the banks.
- bk_dat_i  in  32*NUM_BANKS  bank read data; bank i occupies bits [32i+31:32i].
- bk_ack_i  in  NUM_BANKS  bank acks.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset: all outputs are 0. FSM resets to IDLE. ENABLE resets to all ones. TOFLAG resets to 0. IRQ_EN resets to 0.
- Region index is r = wbs_adr_i[BANK_ADDR_W+3:BANK_ADDR_W].
  - r < NUM_BANKS: bank r.
  - r = 15: CSR window.
  - Any other r: unmapped.
- FSM state IDLE: accepts a request when cyc&stb&!wbs_ack_o. Request fields are latched on that edge.
  - Enabled bank: go to BANK.
  - CSR, unmapped or disabled bank: go to RESP. Reads return 0 except CSR reads; writes are dropped except CSR writes.
- FSM state BANK:
  - bk_stb_o[r] is asserted from the cycle after acceptance; bk_adr_o, bk_dat_o, bk_sel_o and bk_we_o hold the latched values.
  - Watchdog counter starts at 0 and increments each cycle.
  - bk_ack_i[r]=1: capture bk_dat_i slice into wbs_dat_o, drop strobe, go to RESP.
  - Counter reaches TIMEOUT_CYC-1 with no ack: drop strobe, set wbs_dat_o = ERR_DATA|r, set TOFLAG[r], go to RESP.
  - Ack and expiry in the same cycle: the ack wins and no flag is set.
  - Acks from non-selected banks are ignored.
- FSM state RESP: wbs_ack_o=1 for exactly one cycle, then go to IDLE. The !wbs_ack_o qualifier prevents re-issuing the same strobe.
- Latency: bank access acks at cycle (bank ack cycle + 1). CSR, unmapped and disabled accesses ack 2 cycles after acceptance.
- Abort: cyc=0 while in BANK drops bk_stb_o next cycle, returns to IDLE, sets no flag and gives no ack.
- Reset asserted mid-transaction clears all state immediately, including bank strobes.
- CSR map (offset = wbs_adr_i[7:0]; only 32-bit CSR writes are honoured):
  - 0x00 TOFLAG[NUM_BANKS-1:0]: sticky, write-1-to-clear. A set event in the same cycle as a clear wins.
  - 0x04 ENABLE[NUM_BANKS-1:0]: read/write.
  - 0x08 IRQ_EN[0]: read/write.
  - 0x0C ID: read-only; {8'h4E, 8'd NUM_BANKS, 16'h0001}.
  - Other offsets read 0; writes to them are ignored.
- irq_o is registered and equals IRQ_EN & |TOFLAG.

Optional Feature:
- Macro NMX_PERF_CNT_EN.
- Defined:
  - Adds one 32-bit counter per bank, incremented on each completed bank ack; timeouts do not count.
  - Counters wrap at 2^32.
  - CSR offset 0x10+4*i reads counter i; any write to it clears that counter.
  - ID bit 15 reads 1.
- Undefined: no counters, offsets 0x10 and above read 0, ID bit 15 reads 0.

Test Plan:
- After reset, read CSR 0x0C -> 0x4E040001 (0x4E048001 with NMX_PERF_CNT_EN). Read 0x04 -> 0xF.
- Write 0x12345678 to bank 2 offset 0x40 with the bank acking after 3 cycles -> bk_stb_o=4'b0100, bk_adr_o=0x40, bk_dat_o=0x12345678; wbs_ack_o one cycle after the bank ack.
- Read bank 1 with the bank never acking, TIMEOUT_CYC=8, IRQ_EN=1 -> ack with data 0xDEAD0001 after the timeout; TOFLAG=0x2; irq_o=1. Write 0x2 to 0x00 -> TOFLAG=0, irq_o=0.
- Write ENABLE=0xB, then read bank 2 -> bk_stb_o stays 0; ack at cycle 2 with data 0.
- Access region 7 with NUM_BANKS=4 -> ack with data 0; no bank strobe. Drop cyc mid-BANK -> strobe drops next cycle and no ack is produced.
- With NMX_PERF_CNT_EN: 5 bank-0 reads -> CSR 0x10 reads 5. Writing 0x10 -> 0.
